// File: rtl/param_ram_ctrl.sv
// Single-port synchronous RAM with a hardware clear engine and a registered,
// optionally double-registered, read path.
module param_ram_ctrl #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 3,
  parameter logic [DATA_W-1:0] INIT_VAL = '0,
  parameter int                OUT_REG  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              wr_rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              clr,
  output logic              ready,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Handshake: a request is taken on a rising edge only while ready=1;
  // clr on the same edge wins and the request is dropped. While ready=0
  // (clearing) req and clr are ignored, never queued. rd_valid is a single
  // cycle pulse marking the cycle in which data_out carries a completed read.
  typedef enum logic {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_ptr;
  logic              rd_v1;
  logic [DATA_W-1:0] rd_d1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;

  // The clear engine and user writes share the one write port.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = clr_ptr;
    mem_wd = INIT_VAL;
    if (!rst) begin
      if (state == S_CLEAR) begin
        mem_we = 1'b1;
      end else if (req && wr_rd_en && !clr) begin
        mem_we = 1'b1;
        mem_wa = addr;
        mem_wd = data_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_CLEAR;
      clr_ptr <= '0;
      ready   <= 1'b0;
      rd_v1   <= 1'b0;
      rd_d1   <= '0;
    end else begin
      rd_v1 <= 1'b0;
      case (state)
        S_CLEAR: begin
          // Pointer wraps to zero naturally after the last word.
          clr_ptr <= clr_ptr + 1'b1;
          if (clr_ptr == '1) begin
            state <= S_IDLE;
            ready <= 1'b1;
          end
        end
        S_IDLE: begin
          if (clr) begin
            state <= S_CLEAR;
            ready <= 1'b0;
          end else if (req && !wr_rd_en) begin
            rd_v1 <= 1'b1;
            rd_d1 <= mem[addr];
          end
        end
        default: begin
          state <= S_CLEAR;
          ready <= 1'b0;
        end
      endcase
    end
  end

  generate
    if (OUT_REG == 0) begin : g_lat1
      assign data_out = rd_d1;
      assign rd_valid = rd_v1;
    end else begin : g_lat2
      logic              rd_v2;
      logic [DATA_W-1:0] rd_d2;
      // Second stage keeps flowing during a clear so in-flight reads finish.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_v2 <= 1'b0;
          rd_d2 <= '0;
        end else begin
          rd_v2 <= rd_v1;
          if (rd_v1) rd_d2 <= rd_d1;
        end
      end
      assign data_out = rd_d2;
      assign rd_valid = rd_v2;
    end
  endgenerate

endmodule

// File: tb/tb_param_ram_ctrl.sv
// Directed bench for param_ram_ctrl: dut0 has latency 1 and INIT_VAL 0,
// dut1 has latency 2 and INIT_VAL 8'h5A; both share the same input stimulus.
module tb_param_ram_ctrl;

  logic       clk;
  logic       rst;
  logic       req;
  logic       wr_rd_en;
  logic [2:0] addr;
  logic [7:0] data_in;
  logic       clr;
  logic       ready0, ready1;
  logic       rv0, rv1;
  logic [7:0] do0, do1;

  int tests;
  int fails;

  // Expected output state: held data per DUT, plus dut1's extra stage.
  logic [7:0] h0, h1;
  logic       p1v;
  logic [7:0] p1d;

  param_ram_ctrl #(.DATA_W(8), .ADDR_W(3), .INIT_VAL(8'h00), .OUT_REG(0)) dut0 (
    .clk(clk), .rst(rst), .req(req), .wr_rd_en(wr_rd_en), .addr(addr),
    .data_in(data_in), .clr(clr), .ready(ready0), .data_out(do0), .rd_valid(rv0)
  );

  param_ram_ctrl #(.DATA_W(8), .ADDR_W(3), .INIT_VAL(8'h5A), .OUT_REG(1)) dut1 (
    .clk(clk), .rst(rst), .req(req), .wr_rd_en(wr_rd_en), .addr(addr),
    .data_in(data_in), .clr(clr), .ready(ready1), .data_out(do1), .rd_valid(rv1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock of stimulus. acc: a read is expected to be accepted on this
  // edge; e0/e1: the word each DUT should return; er: ready after the edge.
  task automatic step(input logic r, input logic w, input logic [2:0] a,
                      input logic [7:0] d, input logic c, input logic acc,
                      input logic [7:0] e0, input logic [7:0] e1, input logic er);
    req = r; wr_rd_en = w; addr = a; data_in = d; clr = c;
    @(posedge clk);
    #1;
    if (acc) h0 = e0;
    chk("rd_valid0", {7'd0, rv0}, {7'd0, acc});
    chk("data_out0", do0, h0);
    if (p1v) h1 = p1d;
    chk("rd_valid1", {7'd0, rv1}, {7'd0, p1v});
    chk("data_out1", do1, h1);
    p1v = acc;
    p1d = e1;
    chk("ready0", {7'd0, ready0}, {7'd0, er});
    chk("ready1", {7'd0, ready1}, {7'd0, er});
    req = 1'b0; wr_rd_en = 1'b0; clr = 1'b0;
  endtask

  task automatic idle(input logic er);
    step(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, er);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    step(1'b1, 1'b1, a, d, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
  endtask

  task automatic rd(input logic [2:0] a, input logic [7:0] e0, input logic [7:0] e1);
    step(1'b1, 1'b0, a, 8'h00, 1'b0, 1'b1, e0, e1, 1'b1);
  endtask

  // Eight clear cycles; ready must rise only after the eighth edge.
  task automatic run_clear(input logic r, input logic w, input logic [2:0] a, input logic [7:0] d);
    for (int i = 0; i < 8; i++)
      step(r, w, a, d, 1'b0, 1'b0, 8'h00, 8'h00, (i == 7));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_ready0", {7'd0, ready0}, 8'd0);
    chk("rst_ready1", {7'd0, ready1}, 8'd0);
    chk("rst_valid0", {7'd0, rv0}, 8'd0);
    chk("rst_valid1", {7'd0, rv1}, 8'd0);
    chk("rst_data0", do0, 8'h00);
    chk("rst_data1", do1, 8'h00);
    h0 = 8'h00; h1 = 8'h00; p1v = 1'b0; p1d = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    run_clear(1'b0, 1'b0, 3'd0, 8'h00);
  endtask

  initial begin
    tests = 0; fails = 0;
    req = 1'b0; wr_rd_en = 1'b0; addr = 3'd0; data_in = 8'h00; clr = 1'b0;
    rst = 1'b0;
    h0 = 8'h00; h1 = 8'h00; p1v = 1'b0; p1d = 8'h00;

    // Power-up reset and initial clear, then every word holds INIT_VAL.
    do_reset();
    for (int i = 0; i < 8; i++) rd(3'(i), 8'h00, 8'h5A);
    idle(1'b1); idle(1'b1);

    // Single write then read of the same address, then hold.
    wr(3'd0, 8'hAA);
    rd(3'd0, 8'hAA, 8'hAA);
    idle(1'b1); idle(1'b1); idle(1'b1);

    // Streaming writes followed by back-to-back reads.
    for (int i = 0; i < 8; i++) wr(3'(i), 8'h10 + 8'(i));
    for (int i = 0; i < 8; i++) rd(3'(i), 8'h10 + 8'(i), 8'h10 + 8'(i));
    idle(1'b1); idle(1'b1);

    // Read in flight, then clr with a read on the same edge (dropped);
    // writes of 8'hFF to addr 3 during the clear are ignored.
    rd(3'd5, 8'h15, 8'h15);
    step(1'b1, 1'b0, 3'd1, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    run_clear(1'b1, 1'b1, 3'd3, 8'hFF);
    for (int i = 0; i < 8; i++) rd(3'(i), 8'h00, 8'h5A);
    idle(1'b1); idle(1'b1);

    // Reset while a read is in flight: nothing further may pulse.
    wr(3'd2, 8'h33);
    rd(3'd2, 8'h33, 8'h33);
    do_reset();

    // Reset at cycle 4 of an on-demand clear, then a full clear again.
    wr(3'd6, 8'hC3);
    step(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) idle(1'b0);
    do_reset();
    for (int i = 0; i < 8; i++) rd(3'(i), 8'h00, 8'h5A);
    idle(1'b1); idle(1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
